serial_add_ctrl: RTL and testbench
==================================

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 SHALL have parameter NBYTES, default 4, giving the number of byte-serial add steps; operand width W = 8*NBYTES.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset; synchronous and active-low.
REQ-004 SHALL have port in_valid, input, 1, the request is present.
REQ-005 SHALL have port in_ready, output, 1, the block accepts a request this cycle.
REQ-006 SHALL have port op, input, 2, the operation: 00 = a+b, 01 = a-b, 10 = acc+a, 11 = clear acc.
REQ-007 SHALL have ports a and b, input, W each, the operands.
REQ-008 SHALL have port out_valid, output, 1, result, cout and ovf are valid.
REQ-009 SHALL have port out_ready, input, 1, the consumer takes the result.
REQ-010 SHALL have port result, output, W, the sum or difference.
REQ-011 SHALL have port cout, output, 1, the final carry; for subtract, 1 means no borrow.
REQ-012 SHALL have port ovf, output, 1, two's-complement signed overflow.
REQ-013 SHALL have port busy, output, 1, high whenever the state is not IDLE.

Function
REQ-014 SHALL contain exactly one 8-bit add stage (sum = x + y + cin, 8-bit sum plus carry out), reused once per RUN cycle.
REQ-015 SHALL implement FSM states IDLE, RUN and DONE, with in_ready = 1 only in IDLE.
REQ-016 SHALL accept a request on a cycle with IDLE, in_valid = 1 and in_ready = 1, and SHALL latch op, a, b (and acc for op 10) on that edge; operand changes afterwards are ignored.
REQ-017 SHALL transition IDLE->RUN on accept of op 00, 01 or 10, and IDLE->DONE on accept of op 11.
REQ-018 SHALL, in RUN, process byte k (k = 0..NBYTES-1, LSB first) on RUN cycle k, with byte counter 0..NBYTES-1.
REQ-019 SHALL feed the carry out of byte k into the cin of byte k+1.
REQ-020 SHALL use initial cin = 0 for op 00 and 10, and cin = 1 with y = ~b byte for op 01.
REQ-021 SHALL use x = acc byte and y = a byte for op 10.
REQ-022 SHALL go RUN->DONE after byte NBYTES-1, so out_valid rises at cycle T+NBYTES+1 for an accept at cycle T.
REQ-023 SHALL set cout to the carry out of the last byte.
REQ-024 SHALL compute ovf = (x_msb == y_msb) && (result_msb != x_msb), using the effective (inverted-b) operand for subtract.
REQ-025 SHALL make op 11 give result = 0, cout = 0 and ovf = 0, and clear acc.
REQ-026 SHALL load acc with result when ops 00, 01 and 10 complete (entry to DONE).
REQ-027 SHALL hold out_valid, result, cout and ovf stable in DONE until out_ready = 1.
REQ-028 SHALL go DONE->IDLE on the cycle with out_valid && out_ready.
REQ-029 SHALL ignore in_valid in RUN and DONE (no accept, no queueing).
REQ-030 SHALL keep out_valid low outside DONE.
REQ-031 SHALL give a minimum issue interval of NBYTES+2 cycles with out_ready held high.
REQ-032 SHALL wrap results modulo 2^W with no saturation.

Reset
REQ-033 SHALL, while rst_n = 0 at a clock edge, force state IDLE, byte counter 0, acc 0, result 0, cout 0, ovf 0, out_valid 0, busy 0 and in_ready 1 on the following cycle.
REQ-034 SHALL make a reset in RUN or DONE abort the operation, with no out_valid for it afterwards.
REQ-035 SHALL accept a new request on the first cycle with rst_n = 1.

Verification (NBYTES = 4)
REQ-036 SHALL cover: op 00, a = 0x000000FF, b = 0x00000001 accepted at T -> out_valid at T+5, result 0x00000100, cout 0, ovf 0.
REQ-037 SHALL cover: op 00, 0xFFFFFFFF + 0x00000001 -> result 0x00000000, cout 1, ovf 0 (carry ripples through all 4 bytes).
REQ-038 SHALL cover: op 01, 5 - 7 -> 0xFFFFFFFE, cout 0, ovf 0; then 0x80000000 - 1 -> 0x7FFFFFFF, cout 1, ovf 1.
REQ-039 SHALL cover: op 11, then op 10 with a = 10, 20, 30 -> results 10, 30, 60 (0x3C); then clear, op 10 a = 0x7FFFFFFF, op 10 a = 1 -> 0x80000000, ovf 1.
REQ-040 SHALL cover: out_ready low for 3 cycles in DONE while in_valid = 1 with new operands -> result stable, in_ready 0, no accept, IDLE one cycle after out_ready rises.
REQ-041 SHALL cover: rst_n low for 1 cycle during RUN byte 2 -> out_valid never asserts for that request, acc 0, busy 0, in_ready 1, and the next request completes correctly.

Source files
------------

// File: rtl/serial_add_if.sv
// serial_add_if: request/response bundle for serial_add_ctrl.
//   Request  : in_valid, in_ready, op[1:0], a[W-1:0], b[W-1:0]
//   Response : out_valid, out_ready, result[W-1:0], cout, ovf
//   Status   : busy
// The master modport is the requester/consumer side; the slave modport is
// the adder controller.
interface serial_add_if #(
  parameter int NBYTES = 4
);
  localparam int W = 8 * NBYTES;

  logic         in_valid;
  logic         in_ready;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         cout;
  logic         ovf;
  logic         busy;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, cout, ovf, busy
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, cout, ovf, busy
  );
endinterface

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: byte-serial add/subtract/accumulate unit.
// A single 8-bit adder is reused once per RUN cycle, LSB byte first, with
// the carry rippling between cycles through a register.
// Ports:
//   clk   - clock, all state changes on the rising edge
//   rst_n - synchronous active-low reset
//   bus   - serial_add_if slave modport:
//           in_valid/in_ready/op/a/b        request handshake and operands
//           out_valid/out_ready/result/cout/ovf  response handshake and result
//           busy                            high whenever the FSM is not IDLE
// op: 00 = a+b, 01 = a-b, 10 = acc+a, 11 = clear acc (result 0).
module serial_add_ctrl #(
  parameter int NBYTES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  serial_add_if.slave  bus
);
  localparam int W  = 8 * NBYTES;
  localparam int CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [W-1:0]  x_q;        // effective left operand, shifted right per byte
  logic [W-1:0]  y_q;        // effective right operand, shifted right per byte
  logic [W-1:0]  work_q;     // partial result, bytes enter from the top
  logic          carry_q;
  logic [W-1:0]  acc_q;
  logic [W-1:0]  result_q;
  logic          cout_q;
  logic          ovf_q;
  logic          out_valid_q;
  logic          in_ready_q;
  logic          busy_q;

  logic [7:0]    sum_d;
  logic          carry_d;
  logic [W-1:0]  work_d;
  logic          ovf_d;

  // The one and only byte adder: 8-bit sum plus carry out.
  function automatic logic [8:0] add8(input logic [7:0] x,
                                      input logic [7:0] y,
                                      input logic       cin);
    return {1'b0, x} + {1'b0, y} + {8'd0, cin};
  endfunction

  always_comb begin
    {carry_d, sum_d} = add8(x_q[7:0], y_q[7:0], carry_q);
    work_d           = W'({sum_d, work_q} >> 8);
    // On the last byte x_q[7]/y_q[7] are the operand sign bits.
    ovf_d            = (x_q[7] == y_q[7]) && (sum_d[7] != x_q[7]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      x_q         <= '0;
      y_q         <= '0;
      work_q      <= '0;
      carry_q     <= 1'b0;
      acc_q       <= '0;
      result_q    <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          // in_ready is always high here, so in_valid alone marks an accept.
          if (bus.in_valid) begin
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            cnt_q      <= '0;
            work_q     <= '0;
            case (bus.op)
              2'b00: begin
                x_q     <= bus.a;
                y_q     <= bus.b;
                carry_q <= 1'b0;
                state_q <= RUN;
              end
              2'b01: begin
                // a - b == a + ~b + 1
                x_q     <= bus.a;
                y_q     <= ~bus.b;
                carry_q <= 1'b1;
                state_q <= RUN;
              end
              2'b10: begin
                x_q     <= acc_q;
                y_q     <= bus.a;
                carry_q <= 1'b0;
                state_q <= RUN;
              end
              default: begin
                acc_q       <= '0;
                result_q    <= '0;
                cout_q      <= 1'b0;
                ovf_q       <= 1'b0;
                out_valid_q <= 1'b1;
                state_q     <= DONE;
              end
            endcase
          end
        end

        RUN: begin
          x_q     <= x_q >> 8;
          y_q     <= y_q >> 8;
          carry_q <= carry_d;
          work_q  <= work_d;
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            cnt_q       <= '0;
            result_q    <= work_d;
            acc_q       <= work_d;
            cout_q      <= carry_d;
            ovf_q       <= ovf_d;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end

        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end

        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: directed bench for serial_add_ctrl with NBYTES = 4.
module tb_serial_add_ctrl;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  serial_add_if #(.NBYTES(4)) bus ();

  serial_add_ctrl #(.NBYTES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one request, wait for out_valid with a bound, check latency and
  // outputs, then consume the result.
  task automatic run_op(input string tag, input logic [1:0] o,
                        input logic [31:0] av, input logic [31:0] bv,
                        input int lat, input logic [31:0] er,
                        input logic ec, input logic ev);
    int n;
    @(negedge clk);
    chk({tag, ".in_ready_pre"}, 64'(bus.in_ready), 64'd1);
    bus.in_valid  = 1'b1;
    bus.op        = o;
    bus.a         = av;
    bus.b         = bv;
    bus.out_ready = 1'b0;
    @(negedge clk);
    n = 1;
    bus.in_valid = 1'b0;
    bus.a        = 32'hDEADBEEF;
    bus.b        = 32'hCAFEF00D;
    chk({tag, ".busy"}, 64'(bus.busy), 64'd1);
    chk({tag, ".in_ready_busy"}, 64'(bus.in_ready), 64'd0);
    while (!bus.out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, ".latency"}, 64'(n), 64'(lat));
    chk({tag, ".result"}, 64'(bus.result), 64'(er));
    chk({tag, ".cout"}, 64'(bus.cout), 64'(ec));
    chk({tag, ".ovf"}, 64'(bus.ovf), 64'(ev));
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk({tag, ".out_valid_post"}, 64'(bus.out_valid), 64'd0);
    chk({tag, ".in_ready_post"}, 64'(bus.in_ready), 64'd1);
    chk({tag, ".busy_post"}, 64'(bus.busy), 64'd0);
  endtask

  initial begin
    logic [31:0] held;
    bit          saw_valid;
    checks        = 0;
    errors        = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.op        = 2'b00;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst.in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst.busy", 64'(bus.busy), 64'd0);
    chk("rst.out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst.result", 64'(bus.result), 64'd0);
    chk("rst.cout", 64'(bus.cout), 64'd0);
    chk("rst.ovf", 64'(bus.ovf), 64'd0);
    rst_n = 1'b1;

    // Add, carry out of byte 0 only / through all bytes
    run_op("add_ff_1", 2'b00, 32'h000000FF, 32'h00000001, 5, 32'h00000100, 1'b0, 1'b0);
    run_op("add_wrap", 2'b00, 32'hFFFFFFFF, 32'h00000001, 5, 32'h00000000, 1'b1, 1'b0);
    run_op("add_ovf", 2'b00, 32'h7FFFFFFF, 32'h00000001, 5, 32'h80000000, 1'b0, 1'b1);

    // Subtract
    run_op("sub_5_7", 2'b01, 32'd5, 32'd7, 5, 32'hFFFFFFFE, 1'b0, 1'b0);
    run_op("sub_min_1", 2'b01, 32'h80000000, 32'd1, 5, 32'h7FFFFFFF, 1'b1, 1'b1);

    // Clear and accumulate
    run_op("clr0", 2'b11, 32'h12345678, 32'h9ABCDEF0, 1, 32'd0, 1'b0, 1'b0);
    run_op("acc10", 2'b10, 32'd10, 32'd99, 5, 32'd10, 1'b0, 1'b0);
    run_op("acc20", 2'b10, 32'd20, 32'd99, 5, 32'd30, 1'b0, 1'b0);
    run_op("acc30", 2'b10, 32'd30, 32'd99, 5, 32'h3C, 1'b0, 1'b0);
    run_op("clr1", 2'b11, 32'd0, 32'd0, 1, 32'd0, 1'b0, 1'b0);
    run_op("acc_max", 2'b10, 32'h7FFFFFFF, 32'd0, 5, 32'h7FFFFFFF, 1'b0, 1'b0);
    run_op("acc_ovf", 2'b10, 32'd1, 32'd0, 5, 32'h80000000, 1'b0, 1'b1);

    // Back-pressure in DONE while a new request is offered
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.op        = 2'b00;
    bus.a         = 32'h12345678;
    bus.b         = 32'h11111111;
    bus.out_ready = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("bp.out_valid", 64'(bus.out_valid), 64'd1);
    held = bus.result;
    chk("bp.result", 64'(held), 64'h23456789);
    bus.in_valid = 1'b1;
    bus.op       = 2'b11;
    bus.a        = 32'hAAAAAAAA;
    bus.b        = 32'h55555555;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp.hold_result", 64'(bus.result), 64'(held));
      chk("bp.hold_valid", 64'(bus.out_valid), 64'd1);
      chk("bp.hold_in_ready", 64'(bus.in_ready), 64'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("bp.idle_in_ready", 64'(bus.in_ready), 64'd1);
    chk("bp.idle_busy", 64'(bus.busy), 64'd0);
    chk("bp.idle_out_valid", 64'(bus.out_valid), 64'd0);
    @(negedge clk);
    chk("bp.no_accept_busy", 64'(bus.busy), 64'd0);

    // Reset during RUN byte 2
    bus.in_valid = 1'b1;
    bus.op       = 2'b00;
    bus.a        = 32'h01020304;
    bus.b        = 32'h00000010;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rrun.busy", 64'(bus.busy), 64'd0);
    chk("rrun.in_ready", 64'(bus.in_ready), 64'd1);
    chk("rrun.out_valid", 64'(bus.out_valid), 64'd0);
    chk("rrun.result", 64'(bus.result), 64'd0);
    saw_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.out_valid) saw_valid = 1'b1;
    end
    chk("rrun.no_out_valid", 64'(saw_valid), 64'd0);
    // acc was cleared by reset, so acc + 5 must give 5
    run_op("rrun.acc_after", 2'b10, 32'd5, 32'd0, 5, 32'd5, 1'b0, 1'b0);
    run_op("rrun.next_add", 2'b00, 32'h01020304, 32'h00000010, 5, 32'h01020314, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
